ifetch_block: RTL and testbench

IFETCH_BLOCK -- requirements
Module: ifetch_block

---
 rtl/ifetch_block.sv | 122 ++++++++++++
 tb/tb_ifetch_block.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_block.sv
// Single-issue instruction fetch stage: one word per cycle from a combinational
// instruction memory, with NOP insertion for loads, jumps and conditional branches.
module ifetch_block #(
   parameter int BR_TIMEOUT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   output logic [9:0]  imem_addr,
   input  logic [31:0] imem_data,
   input  logic        br_resolve,
   input  logic        br_taken,
   input  logic [9:0]  br_target,
   output logic [31:0] ins,
   output logic        ins_valid,
   output logic [9:0]  pc_out,
   output logic [15:0] issue_cnt,
   output logic        br_timeout,
   output logic [1:0]  dbg_state
);

   // br_resolve is a single-cycle pulse; br_taken and br_target are only
   // meaningful in that cycle, and only while the FSM sits in BR_WAIT.

   localparam int WCW = (BR_TIMEOUT > 1) ? $clog2(BR_TIMEOUT) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(BR_TIMEOUT - 1);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LD_BUBBLE  = 2'd1,
      JMP_BUBBLE = 2'd2,
      BR_WAIT    = 2'd3
   } state_t;

   state_t          state_q;
   logic [9:0]      pc_q;
   logic [31:0]     ins_q;
   logic            ins_valid_q;
   logic [9:0]      pc_out_q;
   logic [15:0]     issue_cnt_q;
   logic            br_timeout_q;
   logic [WCW-1:0]  wait_cnt_q;

   logic [5:0]      opcode_d;
   logic            is_ld_d;
   logic            is_jmp_d;
   logic            is_cj_d;
   logic [9:0]      pc_inc_d;

   assign opcode_d = imem_data[31:26];
   assign is_ld_d  = (opcode_d == 6'b010100);
   assign is_jmp_d = (opcode_d == 6'b011000);
   assign is_cj_d  = (opcode_d[5:2] == 4'b0111);
   assign pc_inc_d = pc_q + 10'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= RUN;
         pc_q         <= '0;
         ins_q        <= '0;
         ins_valid_q  <= 1'b0;
         pc_out_q     <= '0;
         issue_cnt_q  <= '0;
         br_timeout_q <= 1'b0;
         wait_cnt_q   <= '0;
      end else begin
         case (state_q)
            RUN: begin
               if (!stall) begin
                  ins_q       <= imem_data;
                  ins_valid_q <= 1'b1;
                  pc_out_q    <= pc_q;
                  issue_cnt_q <= issue_cnt_q + 16'd1;
                  if (is_jmp_d) begin
                     pc_q    <= imem_data[9:0];
                     state_q <= JMP_BUBBLE;
                  end else if (is_cj_d) begin
                     pc_q       <= pc_inc_d;
                     wait_cnt_q <= '0;
                     state_q    <= BR_WAIT;
                  end else begin
                     pc_q <= pc_inc_d;
                     if (is_ld_d) state_q <= LD_BUBBLE;
                  end
               end
            end
            LD_BUBBLE, JMP_BUBBLE: begin
               if (!stall) begin
                  ins_q       <= '0;
                  ins_valid_q <= 1'b0;
                  state_q     <= RUN;
               end
            end
            BR_WAIT: begin
               // The decode stage sees NOPs here even under stall so the
               // branch wait budget keeps running.
               ins_q       <= '0;
               ins_valid_q <= 1'b0;
               if (br_resolve) begin
                  if (br_taken) pc_q <= br_target;
                  state_q <= RUN;
               end else if (wait_cnt_q == WAIT_LAST) begin
                  br_timeout_q <= 1'b1;
                  state_q      <= RUN;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   assign imem_addr  = pc_q;
   assign ins        = ins_q;
   assign ins_valid  = ins_valid_q;
   assign pc_out     = pc_out_q;
   assign issue_cnt  = issue_cnt_q;
   assign br_timeout = br_timeout_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_ifetch_block.sv
// Directed bench for ifetch_block: plain stream, load/jump bubbles, taken and
// timed-out branches, stall freeze and asynchronous reset mid-branch.
module tb_ifetch_block;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic        br_resolve;
  logic        br_taken;
  logic [9:0]  br_target;
  logic [31:0] ins;
  logic        ins_valid;
  logic [9:0]  pc_out;
  logic [15:0] issue_cnt;
  logic        br_timeout;
  logic [1:0]  dbg_state;

  logic [31:0] mem [0:1023];
  int          tests;
  int          failed;

  ifetch_block #(.BR_TIMEOUT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .br_resolve (br_resolve),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .pc_out     (pc_out),
    .issue_cnt  (issue_cnt),
    .br_timeout (br_timeout),
    .dbg_state  (dbg_state)
  );

  assign imem_data = mem[imem_addr];

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one rising edge, then return on the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    br_resolve = 1'b0;
    br_taken = 1'b0;
    br_target = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] e_ins, input logic e_vld,
                           input logic [9:0] e_pc, input logic [15:0] e_cnt);
    check({tag, ".ins"}, ins, e_ins);
    check({tag, ".vld"}, {31'd0, ins_valid}, {31'd0, e_vld});
    check({tag, ".pc_out"}, {22'd0, pc_out}, {22'd0, e_pc});
    check({tag, ".cnt"}, {16'd0, issue_cnt}, {16'd0, e_cnt});
  endtask

  initial begin
    tests = 0;
    failed = 0;
    reset = 1'b1;
    stall = 1'b0;
    br_resolve = 1'b0;
    br_taken = 1'b0;
    br_target = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    repeat (2) @(negedge clk);

    // reset state
    check_out("rst", 32'h0, 1'b0, 10'd0, 16'd0);
    check("rst.addr", {22'd0, imem_addr}, 32'd0);
    check("rst.tmo", {31'd0, br_timeout}, 32'd0);

    // plain stream
    do_reset();
    mem[0] = 32'h1; mem[1] = 32'h2; mem[2] = 32'h3;
    check("plain.addr0", {22'd0, imem_addr}, 32'd0);
    step(); check_out("plain0", 32'h1, 1'b1, 10'd0, 16'd1);
    step(); check_out("plain1", 32'h2, 1'b1, 10'd1, 16'd2);
    step(); check_out("plain2", 32'h3, 1'b1, 10'd2, 16'd3);

    // load bubble
    do_reset();
    mem[0] = 32'h5000_0000; mem[1] = 32'h11;
    step(); check_out("ld0", 32'h5000_0000, 1'b1, 10'd0, 16'd1);
    check("ld.addr", {22'd0, imem_addr}, 32'd1);
    step(); check_out("ld.nop", 32'h0, 1'b0, 10'd0, 16'd1);
    step(); check_out("ld1", 32'h11, 1'b1, 10'd1, 16'd2);

    // jump
    do_reset();
    mem[0] = 32'h6000_0040; mem[10'h040] = 32'hAB;
    step(); check_out("jmp0", 32'h6000_0040, 1'b1, 10'd0, 16'd1);
    check("jmp.addr", {22'd0, imem_addr}, 32'h40);
    step(); check_out("jmp.nop", 32'h0, 1'b0, 10'd0, 16'd1);
    step(); check_out("jmp1", 32'hAB, 1'b1, 10'h040, 16'd2);

    // taken branch to 0x3FF on the 3rd wait cycle, then wrap to 0
    do_reset();
    mem[0] = 32'h22; mem[5] = 32'h7000_0000; mem[10'h3FF] = 32'h0003_F3FF;
    repeat (5) step();
    step(); check_out("br.cj", 32'h7000_0000, 1'b1, 10'd5, 16'd6);
    step(); check("br.w1", {31'd0, ins_valid}, 32'd0);
    step(); check("br.w2", {31'd0, ins_valid}, 32'd0);
    br_resolve = 1'b1; br_taken = 1'b1; br_target = 10'h3FF;
    step(); check_out("br.w3", 32'h0, 1'b0, 10'd5, 16'd6);
    br_resolve = 1'b0; br_taken = 1'b0; br_target = '0;
    check("br.addr", {22'd0, imem_addr}, 32'h3FF);
    step(); check_out("br.tgt", 32'h0003_F3FF, 1'b1, 10'h3FF, 16'd7);
    step(); check_out("br.wrap", 32'h22, 1'b1, 10'd0, 16'd8);
    check("br.tmo", {31'd0, br_timeout}, 32'd0);

    // timeout: 8 NOPs, sticky flag, resume at CJ+1, stray resolve ignored
    do_reset();
    mem[0] = 32'h7C00_0000; mem[1] = 32'h33; mem[2] = 32'h44;
    step(); check_out("to.cj", 32'h7C00_0000, 1'b1, 10'd0, 16'd1);
    for (int i = 0; i < 7; i++) begin
      step();
      check("to.nop", {31'd0, ins_valid}, 32'd0);
    end
    check("to.pre", {31'd0, br_timeout}, 32'd0);
    step();
    check("to.nop8", {31'd0, ins_valid}, 32'd0);
    check("to.flag", {31'd0, br_timeout}, 32'd1);
    step(); check_out("to.resume", 32'h33, 1'b1, 10'd1, 16'd2);
    br_resolve = 1'b1; br_taken = 1'b1; br_target = 10'h100;
    step(); check_out("to.ignore", 32'h44, 1'b1, 10'd2, 16'd3);
    br_resolve = 1'b0; br_taken = 1'b0; br_target = '0;
    check("to.ign.addr", {22'd0, imem_addr}, 32'd3);
    check("to.sticky", {31'd0, br_timeout}, 32'd1);

    // resolve not-taken on the cycle the timeout would fire
    do_reset();
    mem[0] = 32'h7000_0000; mem[1] = 32'h66;
    step();
    repeat (7) step();
    br_resolve = 1'b1; br_taken = 1'b0; br_target = 10'h200;
    step();
    br_resolve = 1'b0; br_target = '0;
    check("race.tmo", {31'd0, br_timeout}, 32'd0);
    check("race.addr", {22'd0, imem_addr}, 32'd1);
    step(); check_out("race.next", 32'h66, 1'b1, 10'd1, 16'd2);

    // stall freeze for 4 cycles
    do_reset();
    for (int i = 0; i < 4; i++) mem[i] = 32'h10 + i;
    step(); step(); check_out("st.pre", 32'h11, 1'b1, 10'd1, 16'd2);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_out("st.hold", 32'h11, 1'b1, 10'd1, 16'd2);
      check("st.addr", {22'd0, imem_addr}, 32'd2);
    end
    stall = 1'b0;
    step(); check_out("st.go", 32'h12, 1'b1, 10'd2, 16'd3);

    // asynchronous reset mid-BR_WAIT, then clean fetch with no NOP tail
    do_reset();
    mem[0] = 32'h7000_0000;
    step(); step();
    check("ar.state", {30'd0, dbg_state}, 32'd3);
    #2 reset = 1'b1;
    #1;
    check_out("ar.async", 32'h0, 1'b0, 10'd0, 16'd0);
    check("ar.addr", {22'd0, imem_addr}, 32'd0);
    check("ar.state0", {30'd0, dbg_state}, 32'd0);
    mem[0] = 32'h55;
    @(negedge clk);
    reset = 1'b0;
    step(); check_out("ar.fetch", 32'h55, 1'b1, 10'd0, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
